// File: rtl/sram_1rw_req_ctrl_pkg.sv
// Shared types and defaults for the single-port SRAM request controller.
// Sized for the 32 x 16384 1rw macro.
package sram_ctrl_pkg;

  localparam int DEF_BITS       = 32;
  localparam int DEF_WORD_DEPTH = 16384;
  localparam int DEF_ADDR_WIDTH = 14;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/sram_1rw_req_ctrl_resp_fifo.sv
// Two-entry response buffer between the macro read port
// and the response handshake.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [BITS-1:0]  wdata,
  output logic [BITS-1:0]  rdata,
  output logic [CNT_W-1:0] count
);

  logic [BITS-1:0]  mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push &&
    ((cnt_q != CNT_W'(FIFO_DEPTH)) || do_pop);

  assign rdata = mem[rd_ptr];
  assign count = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Request-side controller for the sram_32x16384_1rw macro:
// zero-fill after reset, then credit-gated read/write requests.
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BITS-1:0]       resp_rdata,
  output logic                  init_done,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(WORD_DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  rd_pending_q;
  logic [CNT_W-1:0]      count;
  logic [CNT_W:0]        credit;
  logic                  run;
  logic                  pop;
  logic                  accept;

  assign run = (state_q == RUN);
  assign pop = resp_valid && resp_ready;

  // Slots committed next cycle: buffered + in flight - leaving.
  assign credit = {1'b0, count}
                + {{CNT_W{1'b0}}, rd_pending_q}
                - {{CNT_W{1'b0}}, pop};

  assign req_ready = rst_n && run &&
    (credit < (CNT_W+1)'(FIFO_DEPTH));
  assign accept     = req_valid && req_ready;
  assign resp_valid = rst_n && (count != '0);
  assign init_done  = rst_n && run;

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wd    = '0;
    sram_wmask = '0;
    unique case (state_q)
      INIT: begin
        sram_ce    = rst_n;
        sram_we    = 1'b1;
        sram_addr  = init_cnt_q;
        sram_wd    = '0;
        sram_wmask = '1;
      end
      RUN: begin
        sram_ce    = accept;
        sram_we    = req_we;
        sram_addr  = req_addr;
        sram_wd    = req_wdata;
        sram_wmask = req_wmask;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      rd_pending_q <= accept && !req_we;
      if (state_q == INIT) begin
        if (init_cnt_q == LAST_ADDR) begin
          state_q <= RUN;
        end else begin
          init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  sram_resp_fifo #(
    .BITS (BITS)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pending_q),
    .pop   (pop),
    .wdata (sram_rd),
    .rdata (resp_rdata),
    .count (count)
  );

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Directed bench for sram_1rw_req_ctrl with a behavioural
// masked-write, 1-cycle-read SRAM model attached.
module tb_sram_1rw_req_ctrl;

  localparam int BITS  = 32;
  localparam int DEPTH = 16384;
  localparam int AW    = 14;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [BITS-1:0] req_wdata;
  logic [BITS-1:0] req_wmask;
  logic            resp_valid;
  logic            resp_ready;
  logic [BITS-1:0] resp_rdata;
  logic            init_done;
  logic            sram_ce;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [BITS-1:0] sram_wd;
  logic [BITS-1:0] sram_wmask;
  logic [BITS-1:0] sram_rd;

  int errors = 0;
  int checks = 0;

  logic [BITS-1:0] mem [DEPTH];

  sram_1rw_req_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wd    (sram_wd),
    .sram_wmask (sram_wmask),
    .sram_rd    (sram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-zero background so only the zero-fill can make reads 0.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_A5A5;
    sram_rd = '0;
  end

  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we)
        mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask)
                        | (sram_wd & sram_wmask);
      else
        sram_rd <= mem[sram_addr];
    end
  end

  function automatic logic [BITS-1:0] pat(input int i);
    return 32'h1000_0000 + BITS'(i);
  endfunction

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a,
                          input logic [BITS-1:0] d,
                          input logic [BITS-1:0] m);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    resp_ready = 1'b1;
    drive_rd(14'h0010);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_ready: got %b want 0", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_resp_valid: got %b want 0", resp_valid);
    end
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_init_done: got %b want 0", init_done);
    end
    checks++;
    if (sram_ce !== 1'b0) begin
      errors++;
      $display("FAIL rst_sram_ce: got %b want 0", sram_ce);
    end
    idle();
    @(negedge clk);
  endtask

  // Called at a negedge; releases reset and follows the full sweep.
  task automatic test_init_sweep(input string tag);
    int bad;
    int first;
    bad = 0;
    first = -1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      if (!(sram_ce === 1'b1 && sram_we === 1'b1 &&
            sram_addr === AW'(i) && sram_wd === '0 &&
            sram_wmask === '1 && req_ready === 1'b0 &&
            init_done === 1'b0 && resp_valid === 1'b0)) begin
        if (bad == 0) first = i;
        bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_sweep: %0d bad cycles first at %0d, want 0",
               tag, bad, first);
    end
    #1;
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_init_done: got %b want 1", tag, init_done);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_after: got %b want 1", tag, req_ready);
    end
    checks++;
    if (sram_ce !== 1'b0) begin
      errors++;
      $display("FAIL %s_ce_idle: got %b want 0", tag, sram_ce);
    end
  endtask

  task automatic test_read_zero(input logic [AW-1:0] a,
                                input string tag);
    @(negedge clk);
    resp_ready = 1'b1;
    drive_rd(a);
    #1;
    checks++;
    if (req_ready !== 1'b1 || sram_ce !== 1'b1 || sram_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_issue: got rdy=%b ce=%b we=%b want 1 1 0",
               tag, req_ready, sram_ce, sram_we);
    end
    checks++;
    if (sram_addr !== a) begin
      errors++;
      $display("FAIL %s_addr: got %h want %h", tag, sram_addr, a);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: got %b want 0", tag, resp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s_data: got v=%b %h want 1 00000000",
               tag, resp_valid, resp_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drained: got %b want 0", tag, resp_valid);
    end
  endtask

  task automatic test_write_mask();
    @(negedge clk);
    resp_ready = 1'b1;
    drive_wr(14'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (req_ready !== 1'b1 || sram_ce !== 1'b1 || sram_we !== 1'b1 ||
        sram_wd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr1: got rdy=%b ce=%b we=%b wd=%h want 1 1 1 deadbeef",
               req_ready, sram_ce, sram_we, sram_wd);
    end
    @(negedge clk);
    drive_wr(14'd5, 32'hFFFF_FFFF, 32'h0000_FFFF);
    #1;
    checks++;
    if (req_ready !== 1'b1 || sram_wmask !== 32'h0000_FFFF) begin
      errors++;
      $display("FAIL wr2: got rdy=%b mask=%h want 1 0000ffff",
               req_ready, sram_wmask);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr1_no_resp: got %b want 0", resp_valid);
    end
    @(negedge clk);
    drive_rd(14'd5);
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_issue: got rdy=%b v=%b want 1 0",
               req_ready, resp_valid);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr2_no_resp: got %b want 0", resp_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_FFFF) begin
      errors++;
      $display("FAIL wr_merge: got v=%b %h want 1 deadffff",
               resp_valid, resp_rdata);
    end
    @(negedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_single_resp: got %b want 0", resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_wr(AW'(16 + i), pat(i), 32'hFFFF_FFFF);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_fill%0d: got %b want 1", i, req_ready);
      end
    end
    resp_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k < 8) drive_rd(AW'(16 + k));
      else       idle();
      #1;
      if (k < 8) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready%0d: got %b want 1", k, req_ready);
        end
      end
      if (k >= 2 && k < 10) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== pat(k - 2)) begin
          errors++;
          $display("FAIL b2b_resp%0d: got v=%b %h want 1 %h",
                   k - 2, resp_valid, resp_rdata, pat(k - 2));
        end
      end else begin
        checks++;
        if (resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_quiet%0d: got %b want 0", k, resp_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int   offer  [9]  = '{0, 1, 2, 2, 2, 2, 2, 3, 4};
    bit   exp_rdy[9]  = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
    bit   exp_rv [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int   exp_di [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 0};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      resp_ready = (k >= 6);
      if (k < 9) drive_rd(AW'(16 + offer[k]));
      else       idle();
      #1;
      if (k < 9) begin
        checks++;
        if (req_ready !== exp_rdy[k]) begin
          errors++;
          $display("FAIL bp_ready%0d: got %b want %b",
                   k, req_ready, exp_rdy[k]);
        end
      end
      checks++;
      if (resp_valid !== exp_rv[k] ||
          (exp_rv[k] && resp_rdata !== pat(exp_di[k]))) begin
        errors++;
        $display("FAIL bp_resp%0d: got v=%b %h want %b %h",
                 k, resp_valid, resp_rdata, exp_rv[k], pat(exp_di[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_rd(AW'(16 + k));
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL mid_issue%0d: got %b want 1", k, req_ready);
      end
    end
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 ||
        req_ready !== 1'b0 || sram_ce !== 1'b0) begin
      errors++;
      $display("FAIL mid_gate: got v=%b done=%b rdy=%b ce=%b want 0 0 0 0",
               resp_valid, init_done, req_ready, sram_ce);
    end
    @(negedge clk);
    test_init_sweep("mid");
    test_read_zero(14'd16, "mid_refill");
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    resp_ready = 1'b0;
    test_reset();
    test_init_sweep("init");
    test_read_zero(14'h1234, "rd1234");
    test_write_mask();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_1rw_req_ctrl.md
Name: sram_1rw_req_ctrl

Overview:
- Request-side controller placed directly upstream of the sram_32x16384_1rw single-port macro.
- After reset, zero-fills the whole array, then accepts read/write requests over a valid/ready interface and drives the macro's ce/we/addr/wd/mask pins.
- Captures the 1-cycle-latency read data into a 2-entry response buffer, presented over a valid/ready response interface with full back-pressure.

Parameters:
- BITS, 32, data and mask width.
- WORD_DEPTH, 16384, number of words; zero-fill length.
- ADDR_WIDTH, 14, address width; must satisfy 2^ADDR_WIDTH >= WORD_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  BITS  write data.
- req_wmask  in  BITS  per-bit write enable.
- resp_valid  out  1  read data valid.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  BITS  read data, head of response buffer.
- init_done  out  1  zero-fill complete; stays high until the next reset.
- sram_ce  out  1  to macro ce_in.
- sram_we  out  1  to macro we_in.
- sram_addr  out  ADDR_WIDTH  to macro addr_in.
- sram_wd  out  BITS  to macro wd_in.
- sram_wmask  out  BITS  to macro w_mask_in.
- sram_rd  in  BITS  from macro rd_out; valid in the cycle after a read is issued.

Behaviour:
- Reset state: state = INIT, init counter = 0, rd_pending = 0, buffer empty.
- Outputs while rst_n is low: req_ready = 0, resp_valid = 0, init_done = 0, sram_ce = 0 (gated combinationally by rst_n).
- FSM INIT:
  - Every cycle: sram_ce = 1, sram_we = 1, sram_addr = counter, sram_wd = 0, sram_wmask = all ones.
  - Counter increments each cycle.
  - When counter == WORD_DEPTH-1 is written, go to RUN. The counter does not wrap.
  - req_ready = 0 throughout.
- FSM RUN: init_done = 1. No exit except reset.
- SRAM drive in RUN:
  - sram_ce = req_valid && req_ready.
  - sram_we, sram_addr, sram_wd and sram_wmask pass combinationally from req_we, req_addr, req_wdata and req_wmask.
  - No register stage on this path.
- Credit rule:
  - pop = resp_valid && resp_ready.
  - req_ready = RUN && (count + rd_pending - pop) < 2.
  - req_ready is independent of req_valid and req_we; writes are gated by the same rule.
  - The combinational path resp_ready -> req_ready is intentional.
- Read timing:
  - Read accepted in cycle c: rd_pending = 1 in cycle c+1.
  - sram_rd is written into the buffer at the end of c+1.
  - resp_valid is high from cycle c+2.
- Writes produce no response and never touch the buffer.
- Response buffer: 2-entry FIFO, resp_valid = count > 0.
  - Simultaneous push and pop with count = 2 is impossible by the credit rule.
  - Push and pop in the same cycle at count = 1 leaves count = 1.
- Throughput: back-to-back reads at 1 per cycle are sustained while resp_ready = 1.
- Back-pressure: with resp_ready = 0, at most 2 reads are outstanding (buffer plus pending).
- Reset mid-operation: pending read is discarded, buffer is cleared, init_done drops, and zero-fill restarts at address 0.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum {INIT, RUN};
  - default BITS, WORD_DEPTH and ADDR_WIDTH constants;
  - the FIFO depth constant (2).
- One sub-module, sram_resp_fifo:
  - 2-entry, BITS-wide, synchronous active-low reset;
  - ports push, pop, wdata, rdata, count.

Test Plan:
- Reset release -> sram_ce = 1 and we = 1 for exactly 16384 cycles, addresses 0..16383 in order with wd = 0; init_done rises the cycle after address 16383; req_ready = 0 before that.
- After init, read addr 0x1234 -> resp_rdata = 0x00000000 with resp_valid 2 cycles after acceptance.
- Write 0xDEADBEEF with full mask to addr 5, then write 0xFFFFFFFF with mask 0x0000FFFF to addr 5, then read addr 5 -> 0xDEADFFFF; neither write produces a response.
- 8 back-to-back reads with resp_ready = 1 -> req_ready stays 1, 8 responses on consecutive cycles in request order.
- resp_ready = 0 with 5 reads offered -> exactly 2 accepted and req_ready = 0 after; raising resp_ready drains responses in order and the remaining 3 are then accepted.
- Assert rst_n = 0 for 1 cycle with 1 read pending and 1 buffered -> resp_valid = 0 next cycle, no stale response after release, init sweep restarts at address 0.
